// File: rtl/time_display_driver.sv
// 4-digit HH:MM common-anode 7-segment scanner for the wall-clock time bus.
// Each frame's time is captured once into shadow registers; all pins are driven from flops.
module time_display_driver #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic [3:0] brightness,
    input  logic       blank,
    output logic [3:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic       frame_start
);

    localparam int unsigned      SW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [SW-1:0]    SLOT_LAST = SW'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_DASH  = 7'h40;

    typedef enum logic [1:0] {
        DIG_MIN_U = 2'd0,
        DIG_MIN_T = 2'd1,
        DIG_HR_U  = 2'd2,
        DIG_HR_T  = 2'd3
    } digit_t;

    // Binary to {tens, units}; values below 64 need at most six subtractions.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] rem;
        logic [3:0] tens;
        rem  = v;
        tens = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    digit_t        r_digit;
    digit_t        w_digit_nxt;
    logic [SW-1:0] r_slot;
    logic [SW-1:0] w_slot_nxt;
    logic          w_slot_wrap;
    logic [3:0]    r_pwm;
    logic [3:0]    w_pwm_nxt;
    logic          w_frame_end;

    logic [4:0]    r_sh_hr;
    logic [5:0]    r_sh_min;
    logic [5:0]    r_sh_sec;
    logic [4:0]    w_sh_hr_nxt;
    logic [5:0]    w_sh_min_nxt;
    logic [5:0]    w_sh_sec_nxt;

    logic [7:0]    w_hr_bcd;
    logic [7:0]    w_min_bcd;
    logic          w_hr_bad;
    logic          w_min_bad;
    logic [6:0]    w_seg_on;
    logic [3:0]    w_an_sel;
    logic          w_an_lit;
    logic [3:0]    w_an_n;
    logic          w_dp_n;
    logic          w_fs;

    // Digit scan state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_digit <= DIG_MIN_U;
        end else begin
            r_digit <= w_digit_nxt;
        end
    end

    always_comb begin
        w_slot_wrap = (r_slot == SLOT_LAST);
        w_slot_nxt  = w_slot_wrap ? '0 : r_slot + 1'b1;
        w_pwm_nxt   = r_pwm + 4'd1;
        w_frame_end = w_slot_wrap && (r_digit == DIG_HR_T);
        w_digit_nxt = r_digit;
        if (w_slot_wrap) begin
            case (r_digit)
                DIG_MIN_U: w_digit_nxt = DIG_MIN_T;
                DIG_MIN_T: w_digit_nxt = DIG_HR_U;
                DIG_HR_U:  w_digit_nxt = DIG_HR_T;
                default:   w_digit_nxt = DIG_MIN_U;
            endcase
        end
    end

    always_comb begin
        w_sh_hr_nxt  = r_sh_hr;
        w_sh_min_nxt = r_sh_min;
        w_sh_sec_nxt = r_sh_sec;
        if (w_frame_end) begin
            w_sh_hr_nxt  = hours;
            w_sh_min_nxt = minutes;
            w_sh_sec_nxt = seconds;
        end
    end

    // Outputs are decoded from next-cycle counter/shadow values so the registered
    // pins line up with the counter state they describe (no extra cycle of lag).
    always_comb begin
        w_hr_bcd  = to_bcd({1'b0, w_sh_hr_nxt});
        w_min_bcd = to_bcd(w_sh_min_nxt);
        w_hr_bad  = (w_sh_hr_nxt > 5'd23);
        w_min_bad = (w_sh_min_nxt > 6'd59);

        w_seg_on = SEG_DASH;
        w_an_sel = 4'b0001;
        case (w_digit_nxt)
            DIG_MIN_U: begin
                w_seg_on = w_min_bad ? SEG_DASH : seg_encode(w_min_bcd[3:0]);
                w_an_sel = 4'b0001;
            end
            DIG_MIN_T: begin
                w_seg_on = w_min_bad ? SEG_DASH : seg_encode(w_min_bcd[7:4]);
                w_an_sel = 4'b0010;
            end
            DIG_HR_U: begin
                w_seg_on = w_hr_bad ? SEG_DASH : seg_encode(w_hr_bcd[3:0]);
                w_an_sel = 4'b0100;
            end
            default: begin
                w_seg_on = w_hr_bad ? SEG_DASH : seg_encode(w_hr_bcd[7:4]);
                w_an_sel = 4'b1000;
            end
        endcase

        w_an_lit = (w_slot_nxt != '0) && (w_pwm_nxt < brightness) && !blank;
        w_an_n   = w_an_lit ? ~w_an_sel : 4'hF;
        w_dp_n   = !((w_digit_nxt == DIG_HR_U) && !w_sh_sec_nxt[0]);
        w_fs     = (w_slot_nxt == SLOT_LAST) && (w_digit_nxt == DIG_HR_T);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot      <= '0;
            r_pwm       <= '0;
            r_sh_hr     <= '0;
            r_sh_min    <= '0;
            r_sh_sec    <= '0;
            an_n        <= 4'hF;
            seg_n       <= 7'h7F;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            r_slot      <= w_slot_nxt;
            r_pwm       <= w_pwm_nxt;
            r_sh_hr     <= w_sh_hr_nxt;
            r_sh_min    <= w_sh_min_nxt;
            r_sh_sec    <= w_sh_sec_nxt;
            an_n        <= w_an_n;
            seg_n       <= ~w_seg_on;
            dp_n        <= w_dp_n;
            frame_start <= w_fs;
        end
    end

endmodule

// File: tb/tb_time_display_driver.sv
// Directed bench for time_display_driver with REFRESH_DIV=8 (32-cycle frame).
// n counts clock edges since reset release; outputs are sampled on the falling edge.
module tb_time_display_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [3:0] brightness;
    logic       blank;
    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;
    logic       frame_start;

    int unsigned n;
    int          vectors = 0;
    int          errors  = 0;

    time_display_driver #(.REFRESH_DIV(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .hours       (hours),
        .minutes     (minutes),
        .seconds     (seconds),
        .brightness  (brightness),
        .blank       (blank),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        n = n + 1;
        @(negedge clk);
    endtask

    // Anode pattern for cycle k: slot=k%8, digit=(k/8)%4, pwm=k%16.
    function automatic logic [3:0] exp_an(input int unsigned k, input int unsigned bright,
                                          input logic blk);
        int unsigned slot, pwm, dig;
        logic [3:0] sel;
        slot = k % 8;
        pwm  = k % 16;
        dig  = (k / 8) % 4;
        sel  = 4'b0001 << dig;
        if (k != 0 && slot != 0 && pwm < bright && !blk) return ~sel;
        return 4'hF;
    endfunction

    task automatic test_reset();
        reset = 1'b1; hours = '0; minutes = '0; seconds = '0; brightness = 4'd15; blank = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        vectors++; if (an_n !== 4'hF) begin errors++; $display("FAIL reset_an got %h exp F", an_n); end
        vectors++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h exp 7F", seg_n); end
        vectors++; if (dp_n !== 1'b1) begin errors++; $display("FAIL reset_dp got %b exp 1", dp_n); end
        vectors++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b exp 0", frame_start); end
        hours = 5'd13; minutes = 6'd47; seconds = 6'd10;
        for (int i = 1; i < 32; i++) begin
            tick();
            vectors++; if (seg_n !== 7'h40) begin errors++; $display("FAIL frame0_seg n=%0d got %h exp 40", n, seg_n); end
            vectors++; if (frame_start !== (n == 31)) begin errors++; $display("FAIL frame0_fs n=%0d got %b", n, frame_start); end
            vectors++; if (an_n !== exp_an(n, 15, 1'b0)) begin errors++; $display("FAIL frame0_an n=%0d got %h exp %h", n, an_n, exp_an(n, 15, 1'b0)); end
        end
    endtask

    task automatic test_basic();
        logic [6:0] e [4];
        int unsigned dig;
        e[0] = 7'h78; e[1] = 7'h19; e[2] = 7'h30; e[3] = 7'h79;
        for (int i = 0; i < 64; i++) begin
            tick();
            dig = (n / 8) % 4;
            vectors++; if (seg_n !== e[dig]) begin errors++; $display("FAIL basic_seg n=%0d got %h exp %h", n, seg_n, e[dig]); end
            vectors++; if (dp_n !== (dig != 2)) begin errors++; $display("FAIL basic_dp n=%0d got %b", n, dp_n); end
            vectors++; if (an_n !== exp_an(n, 15, 1'b0)) begin errors++; $display("FAIL basic_an n=%0d got %h exp %h", n, an_n, exp_an(n, 15, 1'b0)); end
            vectors++; if (frame_start !== (n % 32 == 31)) begin errors++; $display("FAIL basic_fs n=%0d got %b", n, frame_start); end
        end
    endtask

    task automatic test_tearing();
        logic [6:0] e [4];
        int unsigned dig;
        e[1] = 7'h19; e[2] = 7'h30; e[3] = 7'h79;
        for (int i = 0; i < 64; i++) begin
            tick();
            dig  = (n / 8) % 4;
            e[0] = (n < 128) ? 7'h78 : 7'h00;
            vectors++; if (seg_n !== e[dig]) begin errors++; $display("FAIL tear_seg n=%0d got %h exp %h", n, seg_n, e[dig]); end
            vectors++; if (frame_start !== (n % 32 == 31)) begin errors++; $display("FAIL tear_fs n=%0d got %b", n, frame_start); end
            if (n == 111) minutes = 6'd48;
        end
    endtask

    task automatic test_dash();
        logic [6:0] ea [4];
        logic [6:0] eb [4];
        int unsigned dig;
        ea[0] = 7'h12; ea[1] = 7'h40; ea[2] = 7'h3F; ea[3] = 7'h3F;
        eb[0] = 7'h3F; eb[1] = 7'h3F; eb[2] = 7'h30; eb[3] = 7'h24;
        hours = 5'd24; minutes = 6'd5;
        for (int i = 0; i < 64; i++) begin
            tick();
            dig = (n / 8) % 4;
            if (n < 192) begin
                vectors++; if (seg_n !== ea[dig]) begin errors++; $display("FAIL dash_hr_seg n=%0d got %h exp %h", n, seg_n, ea[dig]); end
            end else begin
                vectors++; if (seg_n !== eb[dig]) begin errors++; $display("FAIL dash_min_seg n=%0d got %h exp %h", n, seg_n, eb[dig]); end
            end
            if (n == 191) begin hours = 5'd23; minutes = 6'd60; end
        end
    endtask

    task automatic test_pwm();
        int unsigned slot;
        brightness = 4'd0;
        for (int i = 0; i < 32; i++) begin
            tick();
            vectors++; if (an_n !== 4'hF) begin errors++; $display("FAIL pwm0_an n=%0d got %h exp F", n, an_n); end
        end
        brightness = 4'd8;
        for (int i = 0; i < 32; i++) begin
            tick();
            slot = n % 8;
            vectors++; if (an_n !== exp_an(n, 8, 1'b0)) begin errors++; $display("FAIL pwm8_an n=%0d got %h exp %h", n, an_n, exp_an(n, 8, 1'b0)); end
            vectors++; if ($countones(~an_n) > 1) begin errors++; $display("FAIL pwm8_onehot n=%0d got %h exp <=1 low", n, an_n); end
            if (slot == 0) begin
                vectors++; if (an_n !== 4'hF) begin errors++; $display("FAIL pwm8_guard n=%0d got %h exp F", n, an_n); end
            end
        end
        brightness = 4'd15;
    endtask

    task automatic test_colon();
        int unsigned dig;
        seconds = 6'd11;
        for (int i = 0; i < 32; i++) begin
            tick();
            vectors++; if (dp_n !== 1'b1) begin errors++; $display("FAIL colon_odd n=%0d got %b exp 1", n, dp_n); end
        end
        seconds = 6'd12;
        for (int i = 0; i < 32; i++) begin
            tick();
            dig = (n / 8) % 4;
            vectors++; if (dp_n !== (dig != 2)) begin errors++; $display("FAIL colon_even n=%0d got %b exp %b", n, dp_n, (dig != 2)); end
        end
    endtask

    task automatic test_blank();
        logic [6:0] e [4];
        int unsigned dig;
        e[0] = 7'h3F; e[1] = 7'h3F; e[2] = 7'h30; e[3] = 7'h24;
        for (int i = 0; i < 32; i++) begin
            tick();
            dig = (n / 8) % 4;
            vectors++; if (an_n !== exp_an(n, 15, (n > 355))) begin errors++; $display("FAIL blank_an n=%0d got %h exp %h", n, an_n, exp_an(n, 15, (n > 355))); end
            vectors++; if (seg_n !== e[dig]) begin errors++; $display("FAIL blank_seg n=%0d got %h exp %h", n, seg_n, e[dig]); end
            vectors++; if (frame_start !== (n % 32 == 31)) begin errors++; $display("FAIL blank_fs n=%0d got %b", n, frame_start); end
            if (n == 355) blank = 1'b1;
        end
        blank = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [6:0] e [4];
        int unsigned dig;
        for (int i = 0; i < 13; i++) tick();
        reset = 1'b1; hours = 5'd9; minutes = 6'd30;
        @(posedge clk);
        @(negedge clk);
        vectors++; if (an_n !== 4'hF) begin errors++; $display("FAIL rst_mid_an got %h exp F", an_n); end
        vectors++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL rst_mid_seg got %h exp 7F", seg_n); end
        vectors++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_mid_fs got %b exp 0", frame_start); end
        reset = 1'b0;
        n = 0;
        e[0] = 7'h40; e[1] = 7'h30; e[2] = 7'h10; e[3] = 7'h40;
        for (int i = 0; i < 64; i++) begin
            tick();
            dig = (n / 8) % 4;
            if (n < 32) begin
                vectors++; if (seg_n !== 7'h40) begin errors++; $display("FAIL rst_mid_zero n=%0d got %h exp 40", n, seg_n); end
            end else begin
                vectors++; if (seg_n !== e[dig]) begin errors++; $display("FAIL rst_mid_seg2 n=%0d got %h exp %h", n, seg_n, e[dig]); end
            end
            vectors++; if (frame_start !== (n % 32 == 31)) begin errors++; $display("FAIL rst_mid_fs2 n=%0d got %b", n, frame_start); end
            vectors++; if (an_n !== exp_an(n, 15, 1'b0)) begin errors++; $display("FAIL rst_mid_an2 n=%0d got %h exp %h", n, an_n, exp_an(n, 15, 1'b0)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tearing();
        test_dash();
        test_pwm();
        test_colon();
        test_blank();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
